// File: rtl/taylor_trig_accel.sv
// Fixed-point Taylor-series cos/sin accelerator with threshold and term-cap termination.
// One shared multiplier pair evaluates each new term (MUL), which is then tested/accumulated (ACC).
module taylor_trig_accel #(
  parameter int W         = 16,
  parameter int FRAC      = 8,
  parameter int MAX_TERMS = 8
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               start,
  input  logic                               mode,
  input  logic [W-1:0]                       x,
  input  logic [W-1:0]                       y,
  output logic [W-1:0]                       result,
  output logic                               ready,
  output logic [$clog2(MAX_TERMS+1)-1:0]     terms
);
  localparam int TW   = $clog2(MAX_TERMS + 1);
  localparam int PW   = 2 * W;
  localparam int NMAX = 2 * MAX_TERMS;
  localparam int NW   = $clog2(NMAX + 1);
  localparam logic signed [W-1:0] ONE  = W'(longint'(1) << FRAC);
  localparam logic signed [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, INIT, MUL, ACC} state_t;

  // round-half-up(2^FRAC / (n*(n+1))), evaluated at elaboration
  function automatic logic signed [W-1:0] recip_val(input int n);
    longint d;
    longint num;
    if (n < 1) return '0;
    d   = longint'(n) * longint'(n + 1);
    num = (longint'(1) << (FRAC + 1)) + d;
    return W'(num / (2 * d));
  endfunction

  logic signed [W-1:0] recip_lut [NMAX+1];
  for (genvar g = 0; g <= NMAX; g++) begin : g_lut
    assign recip_lut[g] = recip_val(g);
  end

  state_t              state_q, state_d;
  logic signed [W-1:0] x_q, x_d, x2_q, x2_d, term_q, term_d, tnew_q, tnew_d;
  logic signed [W-1:0] sum_q, sum_d, result_q, result_d;
  logic [W-1:0]        y_q, y_d;
  logic                mode_q, mode_d;
  logic [TW-1:0]       k_q, k_d, cnt_q, cnt_d, terms_q, terms_d;

  logic signed [PW-1:0] sq_full, p1_full, p2_full;
  logic signed [W-1:0]  p1, sum_sat;
  logic signed [W:0]    sum_ext;
  logic [W-1:0]         tabs;
  logic [NW-1:0]        n_idx;
  logic [TW-1:0]        cnt_inc;

  always_comb begin
    sq_full = PW'(x_q) * PW'(x_q);
    n_idx   = mode_q ? NW'({k_q, 1'b0}) : NW'({k_q, 1'b0}) - NW'(1);
    p1_full = PW'(term_q) * PW'(x2_q);
    p1      = W'(p1_full >>> FRAC);
    p2_full = PW'(p1) * PW'(recip_lut[n_idx]);
    cnt_inc = cnt_q + TW'(1);

    if (tnew_q == SMIN)   tabs = SMAX;
    else if (tnew_q[W-1]) tabs = -tnew_q;
    else                  tabs = tnew_q;

    sum_ext = (W+1)'(sum_q) + (W+1)'(tnew_q);
    if (sum_ext[W] != sum_ext[W-1]) sum_sat = sum_ext[W] ? SMIN : SMAX;
    else                            sum_sat = sum_ext[W-1:0];
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    mode_d   = mode_q;
    x2_d     = x2_q;
    term_d   = term_q;
    tnew_d   = tnew_q;
    sum_d    = sum_q;
    k_d      = k_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    terms_d  = terms_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          x_d     = x;
          y_d     = y;
          mode_d  = mode;
          state_d = INIT;
        end
      end
      INIT: begin
        x2_d    = W'(sq_full >>> FRAC);
        k_d     = TW'(1);
        term_d  = mode_q ? x_q : ONE;
        sum_d   = mode_q ? x_q : ONE;
        cnt_d   = TW'(1);
        state_d = MUL;
      end
      MUL: begin
        tnew_d  = -W'(p2_full >>> FRAC);
        state_d = ACC;
      end
      ACC: begin
        // A term below threshold is discarded; the published sum excludes it
        if (tabs < y_q) begin
          result_d = sum_q;
          terms_d  = cnt_q;
          state_d  = IDLE;
        end else begin
          sum_d  = sum_sat;
          cnt_d  = cnt_inc;
          term_d = tnew_q;
          k_d    = k_q + TW'(1);
          if (cnt_inc == TW'(MAX_TERMS)) begin
            result_d = sum_sat;
            terms_d  = cnt_inc;
            state_d  = IDLE;
          end else begin
            state_d = MUL;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      mode_q   <= 1'b0;
      x2_q     <= '0;
      term_q   <= '0;
      tnew_q   <= '0;
      sum_q    <= '0;
      k_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      terms_q  <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      mode_q   <= mode_d;
      x2_q     <= x2_d;
      term_q   <= term_d;
      tnew_q   <= tnew_d;
      sum_q    <= sum_d;
      k_q      <= k_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      terms_q  <= terms_d;
    end
  end

  assign ready  = (state_q == IDLE);
  assign result = result_q;
  assign terms  = terms_q;

endmodule

// File: tb/tb_taylor_trig_accel.sv
// Scoreboard bench for taylor_trig_accel: directed vectors push expected result/terms/busy-length;
// a monitor pops and compares on every rising edge of ready.
module tb_taylor_trig_accel;
  localparam int W  = 16;
  localparam int FR = 8;
  localparam int MT = 8;
  localparam int TW = $clog2(MT + 1);

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          mode  = 1'b0;
  logic [W-1:0]  x     = '0;
  logic [W-1:0]  y     = '0;
  logic [W-1:0]  result;
  logic          ready;
  logic [TW-1:0] terms;

  taylor_trig_accel #(.W(W), .FRAC(FR), .MAX_TERMS(MT)) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .mode   (mode),
    .x      (x),
    .y      (y),
    .result (result),
    .ready  (ready),
    .terms  (terms)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0] res;
    int           trm;
    int           lat;   // -1: aborted run, busy length not checked
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: counts busy cycles and checks every completion against the scoreboard
  logic prev_rdy = 1'b1;
  int   lat_cnt  = 0;
  always @(negedge clock) begin
    exp_t e;
    if (ready === 1'b0) begin
      lat_cnt++;
    end else if (ready === 1'b1 && prev_rdy === 1'b0) begin
      if (sb.size() == 0) begin
        check("unexpected_completion", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("result", 32'(result), 32'(e.res));
        check("terms", 32'(terms), 32'(e.trm));
        if (e.lat >= 0) check("busy_cycles", 32'(lat_cnt), 32'(e.lat));
      end
      lat_cnt = 0;
    end
    prev_rdy = ready;
  end

  task automatic wait_idle();
    int t = 0;
    while (ready !== 1'b1 && t < 200) begin
      @(negedge clock);
      t++;
    end
    if (t >= 200) begin
      n_vec++;
      n_err++;
      $display("FAIL idle_timeout: ready still 0x%0h after %0d cycles, expected 1", ready, t);
    end
  endtask

  task automatic run(input logic m, input logic [W-1:0] xv, input logic [W-1:0] yv,
                     input logic [W-1:0] er, input int et, input int el);
    @(negedge clock);
    mode  = m;
    x     = xv;
    y     = yv;
    start = 1'b1;
    sb.push_back('{er, et, el});
    @(negedge clock);
    start = 1'b0;
    wait_idle();
  endtask

  initial begin
    repeat (2) @(negedge clock);
    check("reset_ready", 32'(ready), 32'd1);
    check("reset_result", 32'(result), 32'd0);
    check("reset_terms", 32'(terms), 32'd0);
    reset = 1'b1;

    // cos(pi/3): x2=280, -140 added, 13 rejected
    run(1'b0, 16'h010C, 16'h0066, 16'h0074, 2, 5);
    // tighter threshold: 13 added, 0 rejected
    run(1'b0, 16'h010C, 16'h000A, 16'h0081, 3, 7);
    // sin(pi/3): -49 added, 3 rejected
    run(1'b1, 16'h010C, 16'h000A, 16'h00DB, 2, 5);
    // sin(-pi/3): term0=-268, +50 added, -2 rejected
    run(1'b1, 16'hFEF4, 16'h000A, 16'hFF26, 2, 5);
    // |term| == y keeps going; |term| < y stops
    run(1'b0, 16'h010C, 16'h008C, 16'h0074, 2, 5);
    run(1'b0, 16'h010C, 16'h008D, 16'h0100, 1, 3);
    // x=0: first term is 0, rejected at y=1
    run(1'b0, 16'h0000, 16'h0001, 16'h0100, 1, 3);
    // y=0 runs to the term cap
    run(1'b0, 16'h010C, 16'h0000, 16'h0081, 8, 15);
    repeat (3) @(negedge clock);
    check("result_hold", 32'(result), 32'h0081);
    check("terms_hold", 32'(terms), 32'd8);

    // inputs and start disturbed while busy
    @(negedge clock);
    mode = 1'b0; x = 16'h010C; y = 16'h000A; start = 1'b1;
    sb.push_back('{16'h0081, 3, 7});
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    x = 16'h7FFF; mode = 1'b1; y = 16'h0000; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_idle();

    // start held across completion: back-to-back runs with one idle cycle
    @(negedge clock);
    mode = 1'b0; x = 16'h010C; y = 16'h0066; start = 1'b1;
    sb.push_back('{16'h0074, 2, 5});
    sb.push_back('{16'h0074, 2, 5});
    repeat (7) @(negedge clock);
    start = 1'b0;
    wait_idle();

    // reset during MUL: no result published, outputs cleared
    @(negedge clock);
    mode = 1'b0; x = 16'h010C; y = 16'h0000; start = 1'b1;
    sb.push_back('{16'h0000, 0, -1});
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    check("midreset_ready", 32'(ready), 32'd1);
    check("midreset_result", 32'(result), 32'd0);
    check("midreset_terms", 32'(terms), 32'd0);
    wait_idle();
    run(1'b0, 16'h010C, 16'h0066, 16'h0074, 2, 5);

    repeat (5) @(negedge clock);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    check("final_ready", 32'(ready), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
